// File: rtl/mul_border_acc.sv
// Border cell that multiplies two unsigned magnitudes by unary rate coding.
// It uses bit-reversed counter sequences and counts the product ones into o_acc.
// Optional sign-magnitude output is enabled with `define MUL_BORDER_ACC_SIGN_EN.
module mul_border_acc #(
   parameter int WIDTH = 8,
   parameter int ACC_W = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-2:0] i_data_i,
   input  logic [WIDTH-2:0] i_data_w,
`ifdef MUL_BORDER_ACC_SIGN_EN
   input  logic             i_sign_i,
   input  logic             i_sign_w,
   output logic             o_sign,
`endif
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_bit,
   output logic             o_bit_valid,
   output logic             o_done,
   output logic [ACC_W-1:0] o_acc
);

   localparam int MW = WIDTH - 1;
   localparam logic [MW-1:0]    ONE_M = MW'(1);
   localparam logic [ACC_W-1:0] ONE_A = ACC_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state;
   logic [MW-1:0]   data_i;
   logic [MW-1:0]   data_w;
   logic [MW-1:0]   c_i;
   logic [MW-1:0]   c_w;
   logic [ACC_W-1:0] acc;
   logic [MW-1:0]   rand_i;
   logic [MW-1:0]   rand_w;
   logic            bit_i;
   logic            bit_w;
   logic            run_bit;

   function automatic logic [MW-1:0] bitrev(input logic [MW-1:0] v);
      logic [MW-1:0] r;
      r = '0;
      for (int k = 0; k < MW; k++) r[k] = v[MW-1-k];
      return r;
   endfunction

   always_comb begin
      rand_i  = bitrev(c_i);
      rand_w  = bitrev(c_w);
      bit_i   = (data_i > rand_i);
      bit_w   = (data_w > rand_w);
      run_bit = (state == S_RUN) && bit_i && bit_w;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         data_i <= '0;
         data_w <= '0;
         c_i    <= '0;
         c_w    <= '0;
         acc    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  state  <= S_RUN;
                  data_i <= i_data_i;
                  data_w <= i_data_w;
                  c_i    <= '0;
                  c_w    <= '0;
                  acc    <= '0;
               end
            end
            S_RUN: begin
               // The current cycle's product bit counts even when aborting.
               c_i <= c_i + ONE_M;
               if (bit_i)   c_w <= c_w + ONE_M;
               if (run_bit) acc <= acc + ONE_A;
               if (i_abort)
                  state <= S_IDLE;
               else if (&c_i)
                  state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef MUL_BORDER_ACC_SIGN_EN
   logic sign_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sign_r <= 1'b0;
      else if (state == S_IDLE && i_start)
         sign_r <= i_sign_i ^ i_sign_w;
   end

   assign o_sign = sign_r;
`endif

   assign o_ready     = (state == S_IDLE);
   assign o_busy      = (state == S_RUN);
   assign o_bit_valid = (state == S_RUN);
   assign o_done      = (state == S_DONE);
   assign o_bit       = run_bit;
   assign o_acc       = acc;

endmodule

// File: tb/tb_mul_border_acc.sv
// Scoreboard bench for mul_border_acc at WIDTH=8.
// Expected results are queued at each start and checked by a monitor on o_done.
module tb_mul_border_acc;

   localparam int WIDTH = 8;
   localparam int N     = 128;

   logic       clk;
   logic       rst_n;
   logic       i_start;
   logic       i_abort;
   logic [6:0] i_data_i;
   logic [6:0] i_data_w;
   logic       o_ready;
   logic       o_busy;
   logic       o_bit;
   logic       o_bit_valid;
   logic       o_done;
   logic [7:0] o_acc;
`ifdef MUL_BORDER_ACC_SIGN_EN
   logic       i_sign_i;
   logic       i_sign_w;
   logic       o_sign;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   mul_border_acc #(.WIDTH(WIDTH), .ACC_W(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (i_start),
      .i_abort    (i_abort),
      .i_data_i   (i_data_i),
      .i_data_w   (i_data_w),
`ifdef MUL_BORDER_ACC_SIGN_EN
      .i_sign_i   (i_sign_i),
      .i_sign_w   (i_sign_w),
      .o_sign     (o_sign),
`endif
      .o_ready    (o_ready),
      .o_busy     (o_busy),
      .o_bit      (o_bit),
      .o_bit_valid(o_bit_valid),
      .o_done     (o_done),
      .o_acc      (o_acc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: counts valid cycles and ones per run, compares on each o_done.
   int  vcnt = 0;
   int  ones = 0;
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
         vcnt = 0;
         ones = 0;
      end else begin
         if (o_bit_valid) begin
            if (!prev_valid) begin
               vcnt = 0;
               ones = 0;
            end
            vcnt++;
            if (o_bit) ones++;
         end
         prev_valid = o_bit_valid;
         if (o_done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               check("run_acc", 32'(o_acc), 32'(exp_q.pop_front()));
               check("run_len", 32'(vcnt), 32'(N));
               check("run_ones", 32'(ones), 32'(o_acc));
               check("done_bit_valid", 32'(o_bit_valid), 32'd0);
               check("done_ready", 32'(o_ready), 32'd0);
            end
         end
      end
   end

   task automatic wait_ready();
      int c = 0;
      while (!o_ready && c < 300) begin
         step();
         c++;
      end
      if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      while (!o_done && cnt < 300) begin
         step();
         cnt++;
      end
      if (!o_done) check("done_timeout", 32'(o_done), 32'd1);
   endtask

   task automatic start_run(input logic [6:0] di, input logic [6:0] dw,
                            input bit push, input int exp);
      wait_ready();
      i_start  = 1'b1;
      i_data_i = di;
      i_data_w = dw;
      if (push) exp_q.push_back(exp);
      step();
      i_start  = 1'b0;
      i_data_i = ~di;
      i_data_w = ~dw;
      check("accept_busy", 32'(o_busy), 32'd1);
   endtask

   typedef struct { logic [6:0] di; logic [6:0] dw; int exp; } vec_t;
   vec_t vecs[5];

   initial begin
      int cnt;
      vecs[0] = '{7'd127, 7'd64, 64};
      vecs[1] = '{7'd64,  7'd64, 32};
      vecs[2] = '{7'd127, 7'd127, 127};
      vecs[3] = '{7'd0,   7'd127, 0};
      vecs[4] = '{7'd127, 7'd0,  0};

      rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
      i_data_i = '0; i_data_w = '0;
`ifdef MUL_BORDER_ACC_SIGN_EN
      i_sign_i = 1'b0; i_sign_w = 1'b0;
`endif
      repeat (3) step();
      rst_n = 1'b1;
      step();
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_acc", 32'(o_acc), 32'd0);
      check("rst_bit_valid", 32'(o_bit_valid), 32'd0);
      check("rst_bit", 32'(o_bit), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
`ifdef MUL_BORDER_ACC_SIGN_EN
      check("rst_sign", 32'(o_sign), 32'd0);
`endif
      // Abort while idle must be ignored.
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      check("idle_abort_ready", 32'(o_ready), 32'd1);

      // Directed full runs.
      foreach (vecs[v]) begin
         start_run(vecs[v].di, vecs[v].dw, 1'b1, vecs[v].exp);
         wait_done(cnt);
         check("done_latency", 32'(cnt), 32'd128);
         step();
         check("post_done_ready", 32'(o_ready), 32'd1);
         check("acc_hold", 32'(o_acc), 32'(vecs[v].exp));
      end

      // Abort in the RUN cycle with cI=9: ones in cycles 0..9 are the even ones = 5.
      start_run(7'd127, 7'd64, 1'b0, 0);
      repeat (9) step();
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      check("abort_ready", 32'(o_ready), 32'd1);
      check("abort_done", 32'(o_done), 32'd0);
      check("abort_acc", 32'(o_acc), 32'd5);

      // Immediate restart, with start and abort together: start wins.
      i_start = 1'b1; i_abort = 1'b1;
      i_data_i = 7'd64; i_data_w = 7'd64;
      exp_q.push_back(32);
      step();
      i_start = 1'b0; i_abort = 1'b0;
      check("restart_busy", 32'(o_busy), 32'd1);
      wait_done(cnt);
      check("restart_latency", 32'(cnt), 32'd128);
      step();

      // Start held high: runs every N+2 cycles, mid-run operand changes ignored.
      i_start = 1'b1; i_data_i = 7'd64; i_data_w = 7'd64;
      exp_q.push_back(32);
      step();
      check("cont_accept", 32'(o_busy), 32'd1);
      for (int r = 0; r < 3; r++) begin
         i_data_i = 7'd127; i_data_w = 7'd127;
         repeat (100) step();
         i_data_i = 7'd64; i_data_w = 7'd64;
         wait_done(cnt);
         check("cont_latency", 32'(cnt), 32'd28);
         step();
         check("cont_idle", 32'(o_ready), 32'd1);
         if (r < 2) exp_q.push_back(32);
         else i_start = 1'b0;
         step();
         check("cont_next", 32'(o_busy), (r < 2) ? 32'd1 : 32'd0);
      end

      // Reset dropped mid-run at cI=50.
`ifdef MUL_BORDER_ACC_SIGN_EN
      i_sign_i = 1'b1; i_sign_w = 1'b1;
`endif
      start_run(7'd127, 7'd64, 1'b0, 0);
      repeat (50) step();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 32'(o_ready), 32'd1);
      check("mid_rst_busy", 32'(o_busy), 32'd0);
      check("mid_rst_valid", 32'(o_bit_valid), 32'd0);
      check("mid_rst_bit", 32'(o_bit), 32'd0);
      check("mid_rst_done", 32'(o_done), 32'd0);
      check("mid_rst_acc", 32'(o_acc), 32'd0);
`ifdef MUL_BORDER_ACC_SIGN_EN
      check("mid_rst_sign", 32'(o_sign), 32'd0);
      i_sign_i = 1'b1; i_sign_w = 1'b0;
`endif
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_ready", 32'(o_ready), 32'd1);
      start_run(7'd127, 7'd64, 1'b1, 64);
`ifdef MUL_BORDER_ACC_SIGN_EN
      check("sign_out", 32'(o_sign), 32'd1);
`endif
      wait_done(cnt);
      step();
      step();

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
